// File: rtl/uart_aes_block_assembler_pkg.sv
// Shared definitions for the UART-to-AES block assembler: FSM states,
// default command bytes and AES block geometry.
package uart_aes_block_assembler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RX_KEY,
        ST_RX_PT,
        ST_HOLD_PT
    } state_t;

    localparam logic [7:0]  CMD_KEY_DEFAULT = 8'h4B;   // 'K'
    localparam logic [7:0]  CMD_PT_DEFAULT  = 8'h50;   // 'P'
    localparam int unsigned BLOCK_BYTES     = 16;
    localparam int unsigned BLOCK_BITS      = 128;

endpackage

// File: rtl/uart_aes_block_assembler_shift.sv
// Byte-wide shift register that builds a 128-bit block, first byte in the MSBs.
// Only 15 bytes are stored: o_Block already includes i_Byte, so on the 16th byte
// the complete block is available in the same cycle for registering by the caller.
module aes_byte_shift128
    import uart_aes_block_assembler_pkg::*;
(
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Clr,
    input  logic                  i_Ld,
    input  logic [7:0]            i_Byte,
    output logic [BLOCK_BITS-1:0] o_Block
);

    logic [BLOCK_BITS-9:0] data;

    // Block as it would look once i_Byte is shifted in
    always_comb begin
        o_Block = {data, i_Byte};
    end

    // Shift storage: clear on reset or frame start, shift left one byte on load
    always_ff @(posedge i_Clk) begin
        if (i_Rst || i_Clr) begin
            data <= '0;
        end else if (i_Ld) begin
            data <= o_Block[BLOCK_BITS-9:0];
        end
    end

endmodule

// File: rtl/uart_aes_block_assembler.sv
// Assembles UART RX bytes into 128-bit AES key / plaintext blocks.
// Frame = command byte ('K' or 'P') + 16 data bytes; stalled frames time out.
module uart_aes_block_assembler
    import uart_aes_block_assembler_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = 868,
    parameter int unsigned TIMEOUT_BYTES = 4,
    parameter logic [7:0]  CMD_KEY       = CMD_KEY_DEFAULT,
    parameter logic [7:0]  CMD_PT        = CMD_PT_DEFAULT
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Rx_DV,
    input  logic [7:0]            i_Rx_Byte,
    output logic [BLOCK_BITS-1:0] o_Key,
    output logic                  o_Key_Valid,
    output logic [BLOCK_BITS-1:0] o_Pt,
    output logic                  o_Pt_Valid,
    input  logic                  i_Pt_Ready,
    output logic                  o_Busy,
    output logic                  o_Err
);

    localparam int unsigned TIMEOUT_CLKS = CLKS_PER_BIT * 10 * TIMEOUT_BYTES;
    localparam int unsigned TW           = $clog2(TIMEOUT_CLKS + 1);
    localparam int unsigned CW           = $clog2(BLOCK_BYTES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CLKS);
    localparam logic [CW-1:0] LAST_BYTE   = CW'(BLOCK_BYTES - 1);

    state_t                  state;
    logic [CW-1:0]           count;
    logic [TW-1:0]           timer;
    logic                    shift_clr;
    logic                    shift_ld;
    logic [BLOCK_BITS-1:0]   shift_block;

    aes_byte_shift128 u_shift (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Clr   (shift_clr),
        .i_Ld    (shift_ld),
        .i_Byte  (i_Rx_Byte),
        .o_Block (shift_block)
    );

    // Shift register control: clear on a valid command, shift on each data byte
    always_comb begin
        shift_clr = (state == ST_IDLE) && i_Rx_DV &&
                    ((i_Rx_Byte == CMD_KEY) || (i_Rx_Byte == CMD_PT));
        shift_ld  = ((state == ST_RX_KEY) || (state == ST_RX_PT)) && i_Rx_DV;
    end

    // Frame FSM with byte count, inter-byte timeout and registered outputs
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state       <= ST_IDLE;
            count       <= '0;
            timer       <= '0;
            o_Key       <= '0;
            o_Key_Valid <= 1'b0;
            o_Pt        <= '0;
            o_Pt_Valid  <= 1'b0;
            o_Busy      <= 1'b0;
            o_Err       <= 1'b0;
        end else begin
            o_Key_Valid <= 1'b0;
            o_Err       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_Rx_DV) begin
                        if (i_Rx_Byte == CMD_KEY) begin
                            state  <= ST_RX_KEY;
                            o_Busy <= 1'b1;
                            count  <= '0;
                            timer  <= '0;
                        end else if (i_Rx_Byte == CMD_PT) begin
                            state  <= ST_RX_PT;
                            o_Busy <= 1'b1;
                            count  <= '0;
                            timer  <= '0;
                        end else begin
                            o_Err <= 1'b1;
                        end
                    end
                end
                ST_RX_KEY, ST_RX_PT: begin
                    // An arriving byte takes priority over an expiring timer
                    if (i_Rx_DV) begin
                        timer <= '0;
                        if (count == LAST_BYTE) begin
                            count <= '0;
                            if (state == ST_RX_KEY) begin
                                o_Key       <= shift_block;
                                o_Key_Valid <= 1'b1;
                                state       <= ST_IDLE;
                                o_Busy      <= 1'b0;
                            end else begin
                                o_Pt       <= shift_block;
                                o_Pt_Valid <= 1'b1;
                                state      <= ST_HOLD_PT;
                            end
                        end else begin
                            count <= count + 1'b1;
                        end
                    end else if (timer == TIMEOUT_MAX) begin
                        o_Err  <= 1'b1;
                        state  <= ST_IDLE;
                        o_Busy <= 1'b0;
                        count  <= '0;
                        timer  <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_HOLD_PT: begin
                    if (i_Rx_DV) begin
                        o_Err <= 1'b1;
                    end
                    if (o_Pt_Valid && i_Pt_Ready) begin
                        o_Pt_Valid <= 1'b0;
                        state      <= ST_IDLE;
                        o_Busy     <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_aes_block_assembler.sv
// Self-checking bench for uart_aes_block_assembler: byte strobes are driven
// directly, every cycle is compared against a queue-based frame model, plus a
// constant-expectation vector table and directed corner-case sequences.
module tb_uart_aes_block_assembler;

    localparam int unsigned CPB = 8;
    localparam int unsigned TB  = 4;
    localparam int          TO  = CPB * 10 * TB;   // timeout in clocks (320)
    localparam logic [7:0]  K   = 8'h4B;
    localparam logic [7:0]  P   = 8'h50;

    logic         clk = 1'b0;
    logic         i_Rst = 1'b0;
    logic         i_Rx_DV = 1'b0;
    logic [7:0]   i_Rx_Byte = '0;
    logic         i_Pt_Ready = 1'b0;
    logic [127:0] o_Key;
    logic         o_Key_Valid;
    logic [127:0] o_Pt;
    logic         o_Pt_Valid;
    logic         o_Busy;
    logic         o_Err;

    uart_aes_block_assembler #(
        .CLKS_PER_BIT  (CPB),
        .TIMEOUT_BYTES (TB),
        .CMD_KEY       (K),
        .CMD_PT        (P)
    ) dut (
        .i_Clk       (clk),
        .i_Rst       (i_Rst),
        .i_Rx_DV     (i_Rx_DV),
        .i_Rx_Byte   (i_Rx_Byte),
        .o_Key       (o_Key),
        .o_Key_Valid (o_Key_Valid),
        .o_Pt        (o_Pt),
        .o_Pt_Valid  (o_Pt_Valid),
        .i_Pt_Ready  (i_Pt_Ready),
        .o_Busy      (o_Busy),
        .o_Err       (o_Err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: frame collection as a byte queue
    int           m_mode = 0;    // 0 idle, 1 collecting key, 2 collecting pt, 3 holding pt
    logic [7:0]   m_q[$];
    int           m_gap = 0;
    logic [127:0] e_key = '0;
    logic [127:0] e_pt  = '0;
    bit           e_kv = 0, e_pv = 0, e_busy = 0, e_err = 0;

    function automatic logic [127:0] pack16(input logic [7:0] q[$]);
        logic [127:0] v = '0;
        for (int i = 0; i < 16; i++) v = {v[119:0], q[i]};
        return v;
    endfunction

    task automatic model_step(input bit rst, input bit dv, input logic [7:0] b, input bit rdy);
        e_kv  = 0;
        e_err = 0;
        if (rst) begin
            m_mode = 0; m_q.delete(); m_gap = 0;
            e_key = '0; e_pt = '0; e_pv = 0; e_busy = 0;
            return;
        end
        case (m_mode)
            0: if (dv) begin
                if (b == K)      begin m_mode = 1; m_q.delete(); m_gap = 0; end
                else if (b == P) begin m_mode = 2; m_q.delete(); m_gap = 0; end
                else e_err = 1;
            end
            1, 2: if (dv) begin
                m_q.push_back(b);
                m_gap = 0;
                if (m_q.size() == 16) begin
                    if (m_mode == 1) begin e_key = pack16(m_q); e_kv = 1; m_mode = 0; end
                    else             begin e_pt  = pack16(m_q); e_pv = 1; m_mode = 3; end
                end
            end else begin
                m_gap++;
                if (m_gap > TO) begin e_err = 1; m_mode = 0; end
            end
            default: begin
                if (dv) e_err = 1;
                if (e_pv && rdy) begin e_pv = 0; m_mode = 0; end
            end
        endcase
        e_busy = (m_mode != 0);
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge
    task automatic cycle(input bit rst, input bit dv, input logic [7:0] b, input bit rdy);
        i_Rst = rst; i_Rx_DV = dv; i_Rx_Byte = b; i_Pt_Ready = rdy;
        @(posedge clk);
        model_step(rst, dv, b, rdy);
        @(negedge clk);
        chk("key",      o_Key,       e_key);
        chk("key_valid",o_Key_Valid, e_kv);
        chk("pt",       o_Pt,        e_pt);
        chk("pt_valid", o_Pt_Valid,  e_pv);
        chk("busy",     o_Busy,      e_busy);
        chk("err",      o_Err,       e_err);
    endtask

    task automatic send_bytes(input logic [7:0] q[$], input int gap, input bit rdy);
        foreach (q[i]) begin
            cycle(0, 1, q[i], rdy);
            if (i != q.size() - 1) repeat (gap) cycle(0, 0, 8'h00, rdy);
        end
    endtask

    typedef struct {
        bit rst; bit dv; logic [7:0] b; bit rdy;
        bit e_busy; bit e_err; bit e_kv; bit e_pv;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   q[$];
        logic [127:0] exp_blk;
        int unsigned  r;
        bit           dv, rdy, rst;
        logic [7:0]   b;

        tbl[0] = '{1, 0, 8'h00, 0, 0, 0, 0, 0};   // reset
        tbl[1] = '{0, 1, 8'hA5, 0, 0, 1, 0, 0};   // bad command
        tbl[2] = '{0, 0, 8'h00, 0, 0, 0, 0, 0};
        tbl[3] = '{0, 1, K,     0, 1, 0, 0, 0};   // key frame start
        tbl[4] = '{0, 1, P,     0, 1, 0, 0, 0};   // 'P' as key data
        tbl[5] = '{1, 0, 8'h00, 0, 0, 0, 0, 0};   // reset mid-frame
        tbl[6] = '{0, 1, P,     0, 1, 0, 0, 0};   // pt frame start
        tbl[7] = '{0, 0, 8'h00, 1, 1, 0, 0, 0};
        tbl[8] = '{1, 0, 8'h00, 0, 0, 0, 0, 0};

        @(negedge clk);
        cycle(1, 0, 8'h00, 0);
        chk("reset_key", o_Key, 128'h0);
        chk("reset_pt",  o_Pt,  128'h0);

        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].dv, tbl[i].b, tbl[i].rdy);
            chk("tbl_busy", o_Busy,      tbl[i].e_busy);
            chk("tbl_err",  o_Err,       tbl[i].e_err);
            chk("tbl_kv",   o_Key_Valid, tbl[i].e_kv);
            chk("tbl_pv",   o_Pt_Valid,  tbl[i].e_pv);
        end

        // 1: key 00..0F
        q = {K};
        for (int i = 0; i < 16; i++) q.push_back(8'(i));
        send_bytes(q, 2, 0);
        chk("t1_key", o_Key, 128'h000102030405060708090a0b0c0d0e0f);
        chk("t1_kv",  o_Key_Valid, 1'b1);
        cycle(0, 0, 8'h00, 0);
        chk("t1_kv_pulse", o_Key_Valid, 1'b0);
        chk("t1_busy", o_Busy, 1'b0);

        // 2: plaintext 3F x16, ready held low 100 cycles
        q = {P};
        for (int i = 0; i < 16; i++) q.push_back(8'h3F);
        send_bytes(q, 1, 0);
        chk("t2_pv_first", o_Pt_Valid, 1'b1);
        repeat (100) cycle(0, 0, 8'h00, 0);
        chk("t2_pv_held", o_Pt_Valid, 1'b1);
        chk("t2_pt", o_Pt, {16{8'h3F}});
        cycle(0, 0, 8'h00, 1);
        chk("t2_pv_drop", o_Pt_Valid, 1'b0);
        chk("t2_idle", o_Busy, 1'b0);

        // 3: bad command, then normal key
        cycle(0, 1, 8'hA5, 0);
        chk("t3_err", o_Err, 1'b1);
        chk("t3_busy", o_Busy, 1'b0);
        q = {K};
        exp_blk = '0;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 255));
            q.push_back(b);
            exp_blk = {exp_blk[119:0], b};
        end
        send_bytes(q, 0, 0);
        chk("t3_key", o_Key, exp_blk);

        // 4: timeout boundaries; a byte exactly at the limit is still taken
        q = {P, 8'h01, 8'h02, 8'h03};
        send_bytes(q, 1, 0);
        repeat (TO) cycle(0, 0, 8'h00, 0);
        cycle(0, 1, 8'h04, 0);
        chk("t4_byte_wins_busy", o_Busy, 1'b1);
        chk("t4_byte_wins_err",  o_Err,  1'b0);
        cycle(0, 1, 8'h05, 0);
        repeat (TO) cycle(0, 0, 8'h00, 0);
        chk("t4_pre_to_busy", o_Busy, 1'b1);
        cycle(0, 0, 8'h00, 0);
        chk("t4_to_err",  o_Err,  1'b1);
        chk("t4_to_idle", o_Busy, 1'b0);
        chk("t4_pt_kept", o_Pt, {16{8'h3F}});
        q = {P};
        exp_blk = '0;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 255));
            q.push_back(b);
            exp_blk = {exp_blk[119:0], b};
        end
        send_bytes(q, 3, 0);
        chk("t4_pt_new", o_Pt, exp_blk);
        cycle(0, 0, 8'h00, 1);

        // 5: overrun while holding, including on the transfer cycle
        q = {P};
        for (int i = 0; i < 16; i++) q.push_back(8'(8'hA0 + i));
        send_bytes(q, 0, 0);
        cycle(0, 1, 8'h11, 0);
        chk("t5_err", o_Err, 1'b1);
        chk("t5_pt",  o_Pt, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);
        repeat (3) cycle(0, 0, 8'h00, 0);
        cycle(0, 1, 8'h22, 1);
        chk("t5_xfer_err", o_Err, 1'b1);
        chk("t5_xfer_pv",  o_Pt_Valid, 1'b0);
        chk("t5_xfer_idle", o_Busy, 1'b0);

        // 6: reset after 8th key byte
        q = {K};
        for (int i = 0; i < 8; i++) q.push_back(8'hEE);
        send_bytes(q, 1, 0);
        cycle(1, 0, 8'h00, 0);
        chk("t6_key0",  o_Key, 128'h0);
        chk("t6_pt0",   o_Pt,  128'h0);
        chk("t6_busy0", o_Busy, 1'b0);
        q = {K};
        for (int i = 0; i < 16; i++) q.push_back(8'(8'hF0 ^ i));
        send_bytes(q, 1, 0);
        chk("t6_key", o_Key, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);

        // Random traffic against the model
        for (int n = 0; n < 5000; n++) begin
            r   = $urandom_range(0, 99);
            dv  = (r < 45);
            b   = 8'($urandom_range(0, 255));
            r   = $urandom_range(0, 11);
            if (r == 0) b = K;
            else if (r == 1) b = P;
            rdy = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 999) == 0);
            cycle(rst, dv, b, rdy);
            if ($urandom_range(0, 299) == 0)
                repeat ($urandom_range(TO - 2, TO + 2)) cycle(0, 0, 8'h00, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
